hazard_track_pipe: RTL and testbench
====================================

// Module: hazard_track_pipe
// PURPOSE
//  Parametrised hazard-tracking register chain, the successor to the single-stage ID->E tracker.
//  Each stage (E, M, W, ...) carries {res, a1, a2, a3, tnew} for one instruction.
//  Tnew counts down as the instruction moves through the stages.
//  From this state the block computes two things for the ID-stage instruction: the stall request
//  and the per-operand forwarding select. It sits beside the datapath pipeline registers, between
//  decode and the bypass muxes.
// PARAMETERS
//  STAGES   3   tracked stages after ID (0=E, 1=M, 2=W, ...); legal range 1..7
//  RES_W    2   result-class width; res==0 means "no register write" (bubble/NOP)
//  ADDR_W   5   register-address width
//  TNEW_W   2   width of tnew and tuse fields
//  FWD_W    localparam = $clog2(STAGES+1)
// PORTS
//  clk         in   1                 clock, rising edge
//  reset       in   1                 synchronous, active-high; clears every stage
//  exc_flush   in   1                 exception/eret flush: clears every stage
//  clr         in   1                 inject bubble into stage 0
//  if_flush    in   1                 inject bubble into stage 0 (branch-likely/delay kill)
//  res_id      in   RES_W             result class of ID instruction
//  a1_id       in   ADDR_W            rs address read in ID
//  a2_id       in   ADDR_W            rt address read in ID
//  a3_id       in   ADDR_W            destination address of ID instruction
//  tnew_id     in   TNEW_W            cycles until result ready, valid on entry to stage 0
//  tuse_rs_id  in   TNEW_W            cycles until ID instruction needs rs
//  tuse_rt_id  in   TNEW_W            cycles until ID instruction needs rt
//  res_q       out  STAGES*RES_W      per-stage res; stage k at [k*RES_W +: RES_W]
//  a1_q        out  STAGES*ADDR_W     per-stage a1, same packing
//  a2_q        out  STAGES*ADDR_W     per-stage a2
//  a3_q        out  STAGES*ADDR_W     per-stage a3
//  tnew_q      out  STAGES*TNEW_W     per-stage tnew
//  stall_req   out  1                 combinational; stall IF/ID, bubble into stage 0
//  fwd_rs      out  FWD_W             0 = register file; k+1 = forward from stage k
//  fwd_rt      out  FWD_W             same encoding for rt
// BEHAVIOUR
//  - Reset: all stage fields become 0 at the next edge, so every output is 0 and stall_req/fwd_* = 0.
//    Reset mid-flight discards all tracked instructions.
//  - Priority at each edge:
//    reset | exc_flush > bubble (clr | if_flush | stall_req) > normal load.
//    exc_flush clears ALL stages. A bubble zeroes stage 0 only; stages 1..STAGES-1 still advance.
//  - Stage 0 normal load: {res_id, a1_id, a2_id, a3_id, tnew_id}.
//  - Stage k>0 loads stage k-1 every cycle (stall never freezes E and later).
//    tnew_k <= (tnew_{k-1}==0) ? 0 : tnew_{k-1}-1, saturating at 0.
//  - Last stage is discarded on advance. Latency ID->stage k is k+1 cycles.
//  - A stage matches rs iff res_k!=0 && a3_k!=0 && a3_k==a1_id ($0 never matches). Same for rt with a2_id.
//  - stall_req = OR over k of (match_rs_k && tuse_rs_id < tnew_k) | (match_rt_k && tuse_rt_id < tnew_k).
//  - fwd_rs: take the lowest k that matches (youngest). If its tnew_k==0, fwd_rs=k+1, else 0.
//    An older ready stage is never chosen when a younger one matches. fwd_rt follows the same rule.
//  - res/a1/a2/a3 are unsigned passthrough fields; there is no arithmetic on them.
//    The only arithmetic is the saturating tnew decrement.
//  - All outputs except stall_req/fwd_* are registered. stall_req/fwd_* are pure functions of stage
//    state and ID inputs.
// TESTING
//  1. lw $8 (res=2, a3=8, tnew_id=2), then ID reads rs=$8 with tuse_rs=0
//     -> stall_req=1 for 2 cycles (tnew 2 then 1); 3rd cycle stall_req=0, fwd_rs=3 (W, tnew 0).
//  2. addu $9 (tnew_id=1), then ID reads rt=$9 with tuse_rt=1 -> stall_req=0.
//     Next cycle the instruction is in M with tnew 0 -> fwd_rt=2.
//  3. Writers of $5 in E (tnew 1) and M (tnew 0), ID reads rs=$5 with tuse_rs=1
//     -> fwd_rs=0 (youngest not ready), stall_req=0.
//  4. Stages full, exc_flush=1 together with stall_req=1
//     -> next edge all res_q/a3_q/tnew_q = 0, stall_req=0, fwd_rs=fwd_rt=0.
//  5. a3_id=0 with res_id=1 enters, ID reads rs=$0 with tuse 0 -> never stalls, fwd_rs=0.
//  6. STAGES=5 build: one instruction with tnew_id=3 walks out.
//     -> tnew_q reads 3,2,1,0,0 at stages 0..4; reset asserted at stage 2 clears every stage
//        at the next edge.

Source files
------------

// File: rtl/hazard_track_pipe.sv
// Hazard-tracking register chain beside the datapath pipeline registers.
// It holds {res, a1, a2, a3, tnew} for each stage after ID and derives the stall request and the bypass selects.
module hazard_track_pipe #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned RES_W  = 2,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned TNEW_W = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          exc_flush,
  input  logic                          clr,
  input  logic                          if_flush,
  input  logic [RES_W-1:0]              res_id,
  input  logic [ADDR_W-1:0]             a1_id,
  input  logic [ADDR_W-1:0]             a2_id,
  input  logic [ADDR_W-1:0]             a3_id,
  input  logic [TNEW_W-1:0]             tnew_id,
  input  logic [TNEW_W-1:0]             tuse_rs_id,
  input  logic [TNEW_W-1:0]             tuse_rt_id,
  output logic [STAGES*RES_W-1:0]       res_q,
  output logic [STAGES*ADDR_W-1:0]      a1_q,
  output logic [STAGES*ADDR_W-1:0]      a2_q,
  output logic [STAGES*ADDR_W-1:0]      a3_q,
  output logic [STAGES*TNEW_W-1:0]      tnew_q,
  output logic                          stall_req,
  output logic [$clog2(STAGES+1)-1:0]   fwd_rs,
  output logic [$clog2(STAGES+1)-1:0]   fwd_rt
);

  localparam int unsigned FWD_W = $clog2(STAGES + 1);

  logic [RES_W-1:0]  res_r  [STAGES];
  logic [ADDR_W-1:0] a1_r   [STAGES];
  logic [ADDR_W-1:0] a2_r   [STAGES];
  logic [ADDR_W-1:0] a3_r   [STAGES];
  logic [TNEW_W-1:0] tnew_r [STAGES];

  logic bubble;
  assign bubble = clr | if_flush | stall_req;

  always_ff @(posedge clk) begin
    if (reset || exc_flush) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        res_r[k]  <= '0;
        a1_r[k]   <= '0;
        a2_r[k]   <= '0;
        a3_r[k]   <= '0;
        tnew_r[k] <= '0;
      end
    end else begin
      if (bubble) begin
        res_r[0]  <= '0;
        a1_r[0]   <= '0;
        a2_r[0]   <= '0;
        a3_r[0]   <= '0;
        tnew_r[0] <= '0;
      end else begin
        res_r[0]  <= res_id;
        a1_r[0]   <= a1_id;
        a2_r[0]   <= a2_id;
        a3_r[0]   <= a3_id;
        tnew_r[0] <= tnew_id;
      end
      // Later stages always advance; a stall only holds IF/ID.
      for (int unsigned k = 1; k < STAGES; k++) begin
        res_r[k]  <= res_r[k-1];
        a1_r[k]   <= a1_r[k-1];
        a2_r[k]   <= a2_r[k-1];
        a3_r[k]   <= a3_r[k-1];
        tnew_r[k] <= (tnew_r[k-1] == '0) ? '0 : tnew_r[k-1] - TNEW_W'(1);
      end
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_pack
    assign res_q[g*RES_W +: RES_W]    = res_r[g];
    assign a1_q[g*ADDR_W +: ADDR_W]   = a1_r[g];
    assign a2_q[g*ADDR_W +: ADDR_W]   = a2_r[g];
    assign a3_q[g*ADDR_W +: ADDR_W]   = a3_r[g];
    assign tnew_q[g*TNEW_W +: TNEW_W] = tnew_r[g];
  end

  logic [STAGES-1:0] match_rs;
  logic [STAGES-1:0] match_rt;

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      match_rs[k] = (res_r[k] != '0) && (a3_r[k] != '0) && (a3_r[k] == a1_id);
      match_rt[k] = (res_r[k] != '0) && (a3_r[k] != '0) && (a3_r[k] == a2_id);
    end
  end

  // Youngest matching stage decides the select; an older ready copy is stale.
  always_comb begin
    logic found_rs;
    logic found_rt;
    stall_req = 1'b0;
    fwd_rs    = '0;
    fwd_rt    = '0;
    found_rs  = 1'b0;
    found_rt  = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (match_rs[k] && (tuse_rs_id < tnew_r[k])) stall_req = 1'b1;
      if (match_rt[k] && (tuse_rt_id < tnew_r[k])) stall_req = 1'b1;
      if (match_rs[k] && !found_rs) begin
        found_rs = 1'b1;
        if (tnew_r[k] == '0) fwd_rs = FWD_W'(k + 1);
      end
      if (match_rt[k] && !found_rt) begin
        found_rt = 1'b1;
        if (tnew_r[k] == '0) fwd_rt = FWD_W'(k + 1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_track_pipe.sv
// Directed bench for hazard_track_pipe: a default 3-stage instance plus a 5-stage instance.
module tb_hazard_track_pipe;

  logic       clk = 1'b0;
  logic       reset, exc_flush, clr, if_flush;
  logic [1:0] res_id;
  logic [4:0] a1_id, a2_id, a3_id;
  logic [1:0] tnew_id, tuse_rs_id, tuse_rt_id;

  logic [5:0]  res_q3;
  logic [14:0] a1_q3, a2_q3, a3_q3;
  logic [5:0]  tnew_q3;
  logic        stall3;
  logic [1:0]  fwd_rs3, fwd_rt3;

  logic [9:0]  res_q5;
  logic [24:0] a1_q5, a2_q5, a3_q5;
  logic [9:0]  tnew_q5;
  logic        stall5;
  logic [2:0]  fwd_rs5, fwd_rt5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_track_pipe #(.STAGES(3), .RES_W(2), .ADDR_W(5), .TNEW_W(2)) dut3 (
    .clk(clk), .reset(reset), .exc_flush(exc_flush), .clr(clr), .if_flush(if_flush),
    .res_id(res_id), .a1_id(a1_id), .a2_id(a2_id), .a3_id(a3_id), .tnew_id(tnew_id),
    .tuse_rs_id(tuse_rs_id), .tuse_rt_id(tuse_rt_id),
    .res_q(res_q3), .a1_q(a1_q3), .a2_q(a2_q3), .a3_q(a3_q3), .tnew_q(tnew_q3),
    .stall_req(stall3), .fwd_rs(fwd_rs3), .fwd_rt(fwd_rt3)
  );

  hazard_track_pipe #(.STAGES(5), .RES_W(2), .ADDR_W(5), .TNEW_W(2)) dut5 (
    .clk(clk), .reset(reset), .exc_flush(exc_flush), .clr(clr), .if_flush(if_flush),
    .res_id(res_id), .a1_id(a1_id), .a2_id(a2_id), .a3_id(a3_id), .tnew_id(tnew_id),
    .tuse_rs_id(tuse_rs_id), .tuse_rt_id(tuse_rt_id),
    .res_q(res_q5), .a1_q(a1_q5), .a2_q(a2_q5), .a3_q(a3_q5), .tnew_q(tnew_q5),
    .stall_req(stall5), .fwd_rs(fwd_rs5), .fwd_rt(fwd_rt5)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [1:0] r, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] a3, input logic [1:0] tn,
                        input logic [1:0] urs, input logic [1:0] urt);
    res_id = r; a1_id = a1; a2_id = a2; a3_id = a3; tnew_id = tn;
    tuse_rs_id = urs; tuse_rt_id = urt;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; exc_flush = 1'b0; clr = 1'b0; if_flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);

    // Reset state
    tick();
    chk("rst_res_q", 32'(res_q3), 0);
    chk("rst_a3_q", 32'(a3_q3), 0);
    chk("rst_tnew_q", 32'(tnew_q3), 0);
    chk("rst_stall", 32'(stall3), 0);
    chk("rst_fwd_rs", 32'(fwd_rs3), 0);
    chk("rst_fwd_rt", 32'(fwd_rt3), 0);
    reset = 1'b0;

    // 1: lw $8 tnew 2, consumer rs=$8 tuse 0
    set_id(2, 0, 0, 8, 2, 0, 0);
    tick();
    set_id(0, 8, 0, 0, 0, 0, 0);
    chk("t1_a3_e", 32'(a3_q3), 8);
    chk("t1_stall_e", 32'(stall3), 1);
    tick();
    chk("t1_tnew_m", 32'(tnew_q3), 4);
    chk("t1_stall_m", 32'(stall3), 1);
    tick();
    chk("t1_stall_w", 32'(stall3), 0);
    chk("t1_fwd_rs_w", 32'(fwd_rs3), 3);
    chk("t1_a3_w", 32'(a3_q3), 8 << 10);
    do_reset();

    // 2: addu $9 tnew 1, consumer rt=$9 tuse 1
    set_id(1, 0, 0, 9, 1, 0, 0);
    tick();
    set_id(0, 0, 9, 0, 0, 0, 1);
    chk("t2_stall_e", 32'(stall3), 0);
    chk("t2_fwd_rt_e", 32'(fwd_rt3), 0);
    tick();
    chk("t2_fwd_rt_m", 32'(fwd_rt3), 2);
    chk("t2_stall_m", 32'(stall3), 0);
    do_reset();

    // 3: $5 writers in E (tnew 1) and M (tnew 0)
    set_id(1, 0, 0, 5, 1, 0, 0);
    tick();
    set_id(1, 0, 0, 5, 1, 0, 0);
    tick();
    set_id(0, 5, 0, 0, 0, 1, 0);
    chk("t3_fwd_rs_young", 32'(fwd_rs3), 0);
    chk("t3_stall_tuse1", 32'(stall3), 0);
    set_id(0, 5, 0, 0, 0, 0, 0);
    chk("t3_stall_tuse0", 32'(stall3), 1);
    do_reset();

    // 4: full stages, exc_flush while stalling
    set_id(1, 0, 0, 3, 3, 0, 0);
    tick();
    set_id(1, 0, 0, 4, 3, 0, 0);
    tick();
    set_id(1, 0, 0, 6, 3, 0, 0);
    tick();
    set_id(0, 6, 3, 0, 0, 0, 3);
    chk("t4_a3_full", 32'(a3_q3), 3206);
    chk("t4_tnew_full", 32'(tnew_q3), 27);
    chk("t4_stall_pre", 32'(stall3), 1);
    chk("t4_fwd_rt_pre", 32'(fwd_rt3), 0);
    exc_flush = 1'b1;
    tick();
    exc_flush = 1'b0;
    #1;
    chk("t4_res_flush", 32'(res_q3), 0);
    chk("t4_a3_flush", 32'(a3_q3), 0);
    chk("t4_tnew_flush", 32'(tnew_q3), 0);
    chk("t4_stall_flush", 32'(stall3), 0);
    chk("t4_fwd_rs_flush", 32'(fwd_rs3), 0);
    chk("t4_fwd_rt_flush", 32'(fwd_rt3), 0);

    // 5: writer to $0 never matches
    set_id(1, 0, 0, 0, 3, 0, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    chk("t5_tnew_e", 32'(tnew_q3), 3);
    chk("t5_stall", 32'(stall3), 0);
    chk("t5_fwd_rs", 32'(fwd_rs3), 0);
    do_reset();

    // clr and if_flush bubble stage 0 while later stages advance
    set_id(1, 0, 0, 7, 2, 0, 0);
    tick();
    set_id(2, 0, 0, 10, 1, 0, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_a3", 32'(a3_q3), 224);
    chk("clr_res", 32'(res_q3), 4);
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0;
    chk("ifl_a3", 32'(a3_q3), 7168);
    chk("ifl_tnew", 32'(tnew_q3), 0);
    do_reset();

    // 6: five-stage walk-out, then reset at stage 2
    set_id(1, 0, 0, 12, 3, 0, 0);
    tick();
    set_id(0, 12, 0, 0, 0, 3, 0);
    chk("t6_tnew_s0", 32'(tnew_q5), 3);
    chk("t6_fwd_s0", 32'(fwd_rs5), 0);
    tick();
    chk("t6_tnew_s1", 32'(tnew_q5), 8);
    tick();
    chk("t6_tnew_s2", 32'(tnew_q5), 16);
    tick();
    chk("t6_tnew_s3", 32'(tnew_q5), 0);
    chk("t6_res_s3", 32'(res_q5), 64);
    chk("t6_fwd_s3", 32'(fwd_rs5), 4);
    tick();
    chk("t6_res_s4", 32'(res_q5), 256);
    chk("t6_fwd_s4", 32'(fwd_rs5), 5);
    tick();
    chk("t6_res_gone", 32'(res_q5), 0);
    chk("t6_fwd_gone", 32'(fwd_rs5), 0);
    set_id(1, 0, 0, 12, 3, 0, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("t6_res_s2b", 32'(res_q5), 16);
    do_reset();
    chk("t6_res_rst", 32'(res_q5), 0);
    chk("t6_a3_rst", 32'(a3_q5), 0);
    chk("t6_tnew_rst", 32'(tnew_q5), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
